// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types and constants for the reservation station
//
// Purpose: opcode encodings, instruction field positions, default tag width,
//          the per-entry record and a small width helper used by
//          reservation_station and rs_select.
// Ports:   none (package).
// Config:  entry fields are sized by ENT_DATA_W / ENT_TAG_W; an instance
//          may use DATA_W <= ENT_DATA_W and TAG_W <= ENT_TAG_W.
package rs_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    // Bubble the instruction queue presents when it has nothing to send.
    localparam logic [8:0] INVALID_INSTR = 9'h1FF;

    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 3;
    localparam int RS_MSB = 2;
    localparam int RS_LSB = 0;

    localparam int TAG_W_DEF  = 3;
    localparam int ENT_DATA_W = 16;
    localparam int ENT_TAG_W  = TAG_W_DEF;

    typedef struct packed {
        logic                  busy;
        logic [2:0]            op;
        logic [ENT_DATA_W-1:0] vj;
        logic [ENT_DATA_W-1:0] vk;
        logic [ENT_TAG_W-1:0]  qj;
        logic [ENT_TAG_W-1:0]  qk;
        logic                  pendj;
        logic                  pendk;
    } rs_entry_t;

    // Index / age width for a station of the given depth (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - priority picker over a request vector with optional age
//
// Purpose: returns the requesting entry with the smallest age; ties (and an
//          all-zero age vector) resolve to the lowest index, so the same block
//          serves lowest-free-slot allocation and issue selection.
// Ports:
//   req     in  DEPTH        candidate entries
//   age     in  DEPTH*IDX_W  packed per-entry ages, entry i at [i*IDX_W +: IDX_W]
//   valid   out 1            some entry requested
//   onehot  out DEPTH        selected entry, zero when !valid
//   idx     out IDX_W        index of selected entry, zero when !valid
module rs_select
    import rs_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic [DEPTH-1:0]       req,
    input  logic [DEPTH*IDX_W-1:0] age,
    output logic                   valid,
    output logic [DEPTH-1:0]       onehot,
    output logic [IDX_W-1:0]       idx
);

    logic [IDX_W-1:0] best_age;

    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        best_age = '0;
        // Strict less-than keeps the earliest index on equal ages.
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (!valid || (age[i*IDX_W +: IDX_W] < best_age))) begin
                valid    = 1'b1;
                idx      = IDX_W'(i);
                best_age = age[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        onehot = '0;
        if (valid) begin
            onehot = DEPTH'(1) << idx;
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station for one FU class
//
// Purpose: accepts dispatched instructions of one class (ADD/SUB or MUL/DIV),
//          holds them until both operands are known (register file, same-cycle
//          CDB bypass, or later CDB snoop) and presents one ready entry to the
//          functional unit. Entry i owns producer tag TAG_BASE+i.
// Config:  `define AGE_ORDER_EN to issue the oldest ready entry; otherwise the
//          lowest-index ready entry issues.
// Ports:
//   Clock                in   rising-edge clock
//   Clear                in   synchronous active-high reset
//   dispatchValid        in   instrIn carries a dispatched instruction
//   instrIn[8:0]         in   [8:6] opCode, [5:3] rd, [2:0] rs
//   regValRd/regValRs    in   register-file operand values
//   regPendRd/regPendRs  in   operand still awaits a producer
//   regTagRd/regTagRs    in   producer tag of a pending operand
//   cdbValid/cdbTag/cdbData in common data bus broadcast
//   full                 out  every entry busy
//   allocValid/allocTag  out  entry allocated this cycle and its tag
//   exValid/exOp/exA/exB/exTag out ready entry presented to the FU
//   exReady              in   FU takes the presented entry
module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int OP_CLASS = 0,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int TAG_BASE = 1
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              dispatchValid,
    input  logic [8:0]        instrIn,
    input  logic [DATA_W-1:0] regValRd,
    input  logic [DATA_W-1:0] regValRs,
    input  logic              regPendRd,
    input  logic              regPendRs,
    input  logic [TAG_W-1:0]  regTagRd,
    input  logic [TAG_W-1:0]  regTagRs,
    input  logic              cdbValid,
    input  logic [TAG_W-1:0]  cdbTag,
    input  logic [DATA_W-1:0] cdbData,
    output logic              full,
    output logic              allocValid,
    output logic [TAG_W-1:0]  allocTag,
    output logic              exValid,
    output logic [2:0]        exOp,
    output logic [DATA_W-1:0] exA,
    output logic [DATA_W-1:0] exB,
    output logic [TAG_W-1:0]  exTag,
    input  logic              exReady
);

    localparam int IDX_W = idx_width(DEPTH);

    rs_entry_t ent [DEPTH];
    rs_entry_t new_ent;

    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       ready;
    logic [DEPTH*IDX_W-1:0] age_flat;

    logic                   free_valid;
    logic [DEPTH-1:0]       free_onehot;
    logic [IDX_W-1:0]       free_idx;
    logic                   iss_valid;
    logic [DEPTH-1:0]       iss_onehot;
    logic [IDX_W-1:0]       iss_idx;

    logic                   accept;
    logic                   fire;

    always_comb begin
        busy  = '0;
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy[i]  = ent[i].busy;
            ready[i] = ent[i].busy && !ent[i].pendj && !ent[i].pendk;
        end
    end

    assign full = &busy;

    // Class check: bit 8 low selects the ALU opcodes, bit 7 picks the class.
    // The 9'h1FF bubble fails the bit-8 test.
    assign accept     = dispatchValid && !instrIn[OP_MSB] && (instrIn[7] == OP_CLASS[0]);
    assign allocValid = accept && free_valid && !Clear;
    assign allocTag   = allocValid ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;

    // Lowest free slot: ages are not relevant for allocation.
    rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_alloc_sel (
        .req    (~busy),
        .age    ('0),
        .valid  (free_valid),
        .onehot (free_onehot),
        .idx    (free_idx)
    );

    rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_issue_sel (
        .req    (ready),
        .age    (age_flat),
        .valid  (iss_valid),
        .onehot (iss_onehot),
        .idx    (iss_idx)
    );

    assign exValid = iss_valid && !Clear;
    assign exOp    = ent[iss_idx].op;
    assign exA     = DATA_W'(ent[iss_idx].vj);
    assign exB     = DATA_W'(ent[iss_idx].vk);
    assign exTag   = TAG_W'(TAG_BASE) + TAG_W'(iss_idx);
    assign fire    = exValid && exReady;

    // Operand capture for the incoming instruction. A result broadcast in the
    // same cycle the producer tag is read would otherwise be missed forever.
    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = instrIn[OP_MSB:OP_LSB];
        if (!regPendRd) begin
            new_ent.vj = ENT_DATA_W'(regValRd);
        end else if (cdbValid && (cdbTag == regTagRd)) begin
            new_ent.vj = ENT_DATA_W'(cdbData);
        end else begin
            new_ent.pendj = 1'b1;
            new_ent.qj    = ENT_TAG_W'(regTagRd);
        end
        if (!regPendRs) begin
            new_ent.vk = ENT_DATA_W'(regValRs);
        end else if (cdbValid && (cdbTag == regTagRs)) begin
            new_ent.vk = ENT_DATA_W'(cdbData);
        end else begin
            new_ent.pendk = 1'b1;
            new_ent.qk    = ENT_TAG_W'(regTagRs);
        end
    end

    // Allocation only targets a non-busy slot and issue only a busy one, so
    // the two never hit the same entry in one cycle.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (allocValid && free_onehot[i]) begin
                    ent[i] <= new_ent;
                end else begin
                    if (fire && iss_onehot[i]) begin
                        ent[i].busy <= 1'b0;
                    end
                    if (cdbValid && ent[i].busy && ent[i].pendj &&
                        (TAG_W'(ent[i].qj) == cdbTag)) begin
                        ent[i].vj    <= ENT_DATA_W'(cdbData);
                        ent[i].pendj <= 1'b0;
                    end
                    if (cdbValid && ent[i].busy && ent[i].pendk &&
                        (TAG_W'(ent[i].qk) == cdbTag)) begin
                        ent[i].vk    <= ENT_DATA_W'(cdbData);
                        ent[i].pendk <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef AGE_ORDER_EN
    // Ages of busy entries stay compact in 0..n-1, 0 being the oldest. A new
    // entry lands above every survivor; when an entry leaves, the ones
    // allocated after it move down by one to close the gap.
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] age_q [DEPTH];
    logic [CNT_W-1:0] n_busy;
    logic [IDX_W-1:0] new_age;
    logic [IDX_W-1:0] iss_age;

    always_comb begin
        n_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_busy = n_busy + CNT_W'(busy[i]);
        end
        new_age = IDX_W'(n_busy - CNT_W'(fire));
        iss_age = age_q[iss_idx];
        for (int i = 0; i < DEPTH; i++) begin
            age_flat[i*IDX_W +: IDX_W] = age_q[i];
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (allocValid && free_onehot[i]) begin
                    age_q[i] <= new_age;
                end else if (fire && busy[i] && (age_q[i] > iss_age)) begin
                    age_q[i] <= age_q[i] - 1'b1;
                end
            end
        end
    end
`else
    assign age_flat = '0;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed vector bench for reservation_station
module tb_reservation_station;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        dispatchValid;
    logic [8:0]  instrIn;
    logic [15:0] regValRd, regValRs;
    logic        regPendRd, regPendRs;
    logic [2:0]  regTagRd, regTagRs;
    logic        cdbValid;
    logic [2:0]  cdbTag;
    logic [15:0] cdbData;
    logic        full, allocValid, exValid, exReady;
    logic [2:0]  allocTag, exOp, exTag;
    logic [15:0] exA, exB;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    reservation_station dut (
        .Clock         (Clock),
        .Clear         (Clear),
        .dispatchValid (dispatchValid),
        .instrIn       (instrIn),
        .regValRd      (regValRd),
        .regValRs      (regValRs),
        .regPendRd     (regPendRd),
        .regPendRs     (regPendRs),
        .regTagRd      (regTagRd),
        .regTagRs      (regTagRs),
        .cdbValid      (cdbValid),
        .cdbTag        (cdbTag),
        .cdbData       (cdbData),
        .full          (full),
        .allocValid    (allocValid),
        .allocTag      (allocTag),
        .exValid       (exValid),
        .exOp          (exOp),
        .exA           (exA),
        .exB           (exB),
        .exTag         (exTag),
        .exReady       (exReady)
    );

    typedef struct {
        logic        clr;
        logic        dv;
        logic [8:0]  instr;
        logic [15:0] vrd, vrs;
        logic        prd, prs;
        logic [2:0]  trd, trs;
        logic        cv;
        logic [2:0]  ctag;
        logic [15:0] cdata;
        logic        exr;
        logic        e_full, e_av;
        logic [2:0]  e_atag;
        logic        e_exv;
        logic [2:0]  e_op;
        logic [15:0] e_a, e_b;
        logic [2:0]  e_tag;
    } vec_t;

    vec_t tv[$];

    localparam logic [8:0] I_ADD = 9'b000_001_010;
    localparam logic [8:0] I_SUB = 9'b001_011_100;
    localparam logic [8:0] I_MUL = 9'b010_000_001;
    localparam logic [8:0] I_DIV = 9'b011_000_001;

    function automatic vec_t n();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t d(input logic [8:0] ins, input logic [15:0] a, input logic [15:0] b,
                               input logic pa, input logic [2:0] ta,
                               input logic pb, input logic [2:0] tb);
        vec_t v;
        v = n();
        v.dv = 1'b1; v.instr = ins; v.vrd = a; v.vrs = b;
        v.prd = pa; v.trd = ta; v.prs = pb; v.trs = tb;
        return v;
    endfunction

    function automatic vec_t c(input vec_t vi, input logic [2:0] tag, input logic [15:0] data);
        vec_t v;
        v = vi;
        v.cv = 1'b1; v.ctag = tag; v.cdata = data;
        return v;
    endfunction

    function automatic vec_t x(input vec_t vi);
        vec_t v;
        v = vi;
        v.exr = 1'b1;
        return v;
    endfunction

    function automatic vec_t e(input vec_t vi, input logic f, input logic av, input logic [2:0] at,
                               input logic exv, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b, input logic [2:0] tag);
        vec_t v;
        v = vi;
        v.e_full = f; v.e_av = av; v.e_atag = at;
        v.e_exv = exv; v.e_op = op; v.e_a = a; v.e_b = b; v.e_tag = tag;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        @(negedge Clock);
        Clear         = v.clr;
        dispatchValid = v.dv;
        instrIn       = v.instr;
        regValRd      = v.vrd;
        regValRs      = v.vrs;
        regPendRd     = v.prd;
        regPendRs     = v.prs;
        regTagRd      = v.trd;
        regTagRs      = v.trs;
        cdbValid      = v.cv;
        cdbTag        = v.ctag;
        cdbData       = v.cdata;
        exReady       = v.exr;
        #1;
        chk("full", row, 16'(full), 16'(v.e_full));
        chk("allocValid", row, 16'(allocValid), 16'(v.e_av));
        if (v.e_av) chk("allocTag", row, 16'(allocTag), 16'(v.e_atag));
        chk("exValid", row, 16'(exValid), 16'(v.e_exv));
        if (v.e_exv) begin
            chk("exOp", row, 16'(exOp), 16'(v.e_op));
            chk("exA", row, exA, v.e_a);
            chk("exB", row, exB, v.e_b);
            chk("exTag", row, 16'(exTag), 16'(v.e_tag));
        end
    endtask

    logic [2:0]  ord_tag [3];
    logic [15:0] ord_b   [3];

    initial begin
        vec_t v;

        // Reset state and simple ADD
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(d(I_ADD, 5, 7, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(e(x(n()), 0, 0, 0, 1, 3'b000, 5, 7, 1));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        // Fill with SUBs, drop when full, free one
        tv.push_back(e(d(I_SUB, 1, 2, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(e(d(I_SUB, 3, 4, 0, 0, 0, 0), 0, 1, 2, 1, 3'b001, 1, 2, 1));
        tv.push_back(e(d(I_SUB, 5, 6, 0, 0, 0, 0), 0, 1, 3, 1, 3'b001, 1, 2, 1));
        tv.push_back(e(x(d(I_SUB, 8, 9, 0, 0, 0, 0)), 1, 0, 0, 1, 3'b001, 1, 2, 1));
        tv.push_back(e(x(n()), 0, 0, 0, 1, 3'b001, 3, 4, 2));
        tv.push_back(e(x(n()), 0, 0, 0, 1, 3'b001, 5, 6, 3));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        // CDB wakeup of rs operand
        tv.push_back(e(d(9'b000_010_011, 16'h0011, 0, 0, 0, 1, 5), 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(c(n(), 5, 16'h00AA), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(x(n()), 0, 0, 0, 1, 3'b000, 16'h0011, 16'h00AA, 1));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        // Same-cycle bypass on rd
        tv.push_back(e(c(d(I_ADD, 0, 3, 1, 4, 0, 0), 4, 9), 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(e(x(n()), 0, 0, 0, 1, 3'b000, 9, 3, 1));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        // Wrong class and bubble ignored
        tv.push_back(e(d(I_MUL, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(d(9'h1FF, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(d(I_DIV, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        // Clear with two busy entries, a CDB hit and a dispatch
        tv.push_back(e(d(I_ADD, 0, 1, 1, 6, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(e(d(I_ADD, 0, 1, 1, 6, 0, 0), 0, 1, 2, 0, 0, 0, 0, 0));
        v = c(d(I_ADD, 2, 2, 0, 0, 0, 0), 6, 16'h0055);
        v.clr = 1'b1;
        tv.push_back(e(v, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(c(n(), 6, 16'h0055), 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));
        // Own tag on the CDB while dispatching a ready instruction is ignored
        tv.push_back(e(c(d(I_ADD, 16'h0021, 16'h0022, 0, 0, 0, 0), 1, 16'h0099), 0, 1, 1, 0, 0, 0, 0, 0));
        tv.push_back(e(x(c(n(), 1, 16'h0099)), 0, 0, 0, 1, 3'b000, 16'h0021, 16'h0022, 1));
        tv.push_back(e(n(), 0, 0, 0, 0, 0, 0, 0, 0));

        Clear = 1'b1; dispatchValid = 1'b0; instrIn = 9'h1FF;
        regValRd = '0; regValRs = '0; regPendRd = 1'b0; regPendRs = 1'b0;
        regTagRd = '0; regTagRs = '0; cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
        exReady = 1'b0;
        repeat (2) @(posedge Clock);

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i], i);
        end

        // Issue order after out-of-order slot reuse: allocation order is
        // entry 2, entry 0, entry 1, then all three become ready together.
`ifdef AGE_ORDER_EN
        ord_tag[0] = 3; ord_b[0] = 16'h0050;
        ord_tag[1] = 1; ord_b[1] = 16'h0060;
        ord_tag[2] = 2; ord_b[2] = 16'h0070;
`else
        ord_tag[0] = 1; ord_b[0] = 16'h0060;
        ord_tag[1] = 2; ord_b[1] = 16'h0070;
        ord_tag[2] = 3; ord_b[2] = 16'h0050;
`endif
        apply(e(d(I_ADD, 16'h0010, 16'h0020, 0, 0, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0), 100);
        apply(e(d(I_ADD, 16'h0030, 16'h0040, 0, 0, 0, 0), 0, 1, 2, 1, 3'b000, 16'h0010, 16'h0020, 1), 101);
        apply(e(d(I_ADD, 0, 16'h0050, 1, 7, 0, 0), 0, 1, 3, 1, 3'b000, 16'h0010, 16'h0020, 1), 102);
        apply(e(x(n()), 1, 0, 0, 1, 3'b000, 16'h0010, 16'h0020, 1), 103);
        apply(e(x(n()), 0, 0, 0, 1, 3'b000, 16'h0030, 16'h0040, 2), 104);
        apply(e(d(I_ADD, 0, 16'h0060, 1, 7, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0), 105);
        apply(e(d(I_ADD, 0, 16'h0070, 1, 7, 0, 0), 0, 1, 2, 0, 0, 0, 0, 0), 106);
        apply(e(c(n(), 7, 16'h0077), 1, 0, 0, 0, 0, 0, 0, 0), 107);
        for (int k = 0; k < 3; k++) begin
            apply(e(x(n()), (k == 0), 0, 0, 1, 3'b000, 16'h0077, ord_b[k], ord_tag[k]), 108 + k);
        end
        apply(e(n(), 0, 0, 0, 0, 0, 0, 0, 0), 111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
